// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU with iterative (one bit per cycle) multiply and
// divide. Mul/div results go to HI/LO; MFHI/MFLO read them back.
module alu_muldiv #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_control,
   input  logic [WIDTH-1:0]   data1,
   input  logic [WIDTH-1:0]   data2,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out,
   output logic               zero,
   output logic               busy
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_MFHI  = 4'b0011;
   localparam logic [3:0] OP_MULT  = 4'b0100;
   localparam logic [3:0] OP_MULTU = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_SLL   = 4'b1001;
   localparam logic [3:0] OP_SRL   = 4'b1010;
   localparam logic [3:0] OP_SRA   = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_DIV   = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;
   localparam logic [3:0] OP_MFLO  = 4'b1111;

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     count;
   logic [WIDTH-1:0]     hi, lo, opb, a_orig;
   logic [2*WIDTH-1:0]   acc;
   logic                 neg_res, neg_rem, div_zero;
   logic                 accept, is_mul, is_div, last;
   logic                 sgn, a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag, alu_res;
   logic [WIDTH:0]       mul_sum, div_trial;
   logic [2*WIDTH-1:0]   mul_nxt, div_nxt, mul_fin;
   logic [WIDTH-1:0]     quo, rem, fin_hi, fin_lo;

   assign busy     = (state != IDLE);
   assign in_ready = !busy;
   assign accept   = in_valid && in_ready;
   assign is_mul   = (alu_control == OP_MULT) || (alu_control == OP_MULTU);
   assign is_div   = (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
   assign last     = (count == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: leave IDLE on accepting mul/div, return after WIDTH iterations.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && is_mul)      state_nxt = MUL;
            else if (accept && is_div) state_nxt = DIV;
         end
         MUL, DIV: if (last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Single-cycle result selection.
   always_comb begin
      alu_res = '0;
      case (alu_control)
         OP_AND:  alu_res = data1 & data2;
         OP_OR:   alu_res = data1 | data2;
         OP_ADD:  alu_res = data1 + data2;
         OP_SUB:  alu_res = data1 - data2;
         OP_NOR:  alu_res = ~(data1 | data2);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
         OP_SLL:  alu_res = data2 << shamt;
         OP_SRL:  alu_res = data2 >> shamt;
         OP_SRA:  alu_res = $signed(data2) >>> shamt;
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   // Operand magnitudes: signed ops iterate on |a|,|b| and fix signs at the end.
   always_comb begin
      sgn   = (alu_control == OP_MULT) || (alu_control == OP_DIV);
      a_neg = sgn && data1[WIDTH-1];
      b_neg = sgn && data2[WIDTH-1];
      a_mag = a_neg ? -data1 : data1;
      b_mag = b_neg ? -data2 : data2;
   end

   // One iteration step plus the sign-corrected final results.
   // acc holds {partial product, multiplier} for MUL and {remainder, dividend} for DIV.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
      div_nxt   = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      mul_fin   = neg_res ? -mul_nxt : mul_nxt;
      quo       = neg_res ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
      rem       = neg_rem ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
      fin_hi    = rem;
      fin_lo    = quo;
      if (state == MUL) begin
         fin_hi = mul_fin[2*WIDTH-1:WIDTH];
         fin_lo = mul_fin[WIDTH-1:0];
      end else if (div_zero) begin
         fin_hi = a_orig;
         fin_lo = '1;
      end
   end

   // Datapath: operand capture, iteration, result/HI/LO registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         zero      <= 1'b1;
         hi        <= '0;
         lo        <= '0;
         count     <= '0;
         acc       <= '0;
         opb       <= '0;
         a_orig    <= '0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     acc     <= {{WIDTH{1'b0}}, b_mag};
                     opb     <= a_mag;
                     neg_res <= a_neg ^ b_neg;
                     count   <= '0;
                  end else if (is_div) begin
                     acc      <= {{WIDTH{1'b0}}, a_mag};
                     opb      <= b_mag;
                     neg_res  <= a_neg ^ b_neg;
                     neg_rem  <= a_neg;
                     div_zero <= (data2 == '0);
                     a_orig   <= data1;
                     count    <= '0;
                  end else begin
                     out       <= alu_res;
                     zero      <= (alu_res == '0);
                     out_valid <= 1'b1;
                  end
               end
            end
            MUL, DIV: begin
               acc   <= (state == MUL) ? mul_nxt : div_nxt;
               count <= count + 1'b1;
               if (last) begin
                  hi        <= fin_hi;
                  lo        <= fin_lo;
                  out       <= fin_lo;
                  zero      <= (fin_lo == '0);
                  out_valid <= 1'b1;
                  count     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver pushes expected results from a
// behavioural model, a monitor pops and compares on every out_valid.
module tb_alu_muldiv;

   localparam int W  = 32;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    alu_control = 4'd0;
   logic [W-1:0]  data1 = '0, data2 = '0;
   logic [SW-1:0] shamt = '0;
   logic          out_valid, zero, busy;
   logic [W-1:0]  out;

   alu_muldiv #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .data1(data1), .data2(data2), .shamt(shamt),
      .out_valid(out_valid), .out(out), .zero(zero), .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [W-1:0] val;
      int unsigned  cyc;
      logic [3:0]   op;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   // Reference model: plain arithmetic on 64-bit integers.
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                 input logic [SW-1:0] sh,
                                 output logic [W-1:0] res, output bit multi);
      longint            sa, sb_, sp, q, r;
      longint unsigned   ua, ub, up;
      multi = 0;
      res   = '0;
      case (op)
         4'b0000: res = a & b;
         4'b0001: res = a | b;
         4'b0010: res = a + b;
         4'b0110: res = a - b;
         4'b1100: res = ~(a | b);
         4'b0111: res = ($signed(a) < $signed(b)) ? 1 : 0;
         4'b1000: res = (a < b) ? 1 : 0;
         4'b1001: res = b << sh;
         4'b1010: res = b >> sh;
         4'b1011: res = $signed(b) >>> sh;
         4'b0011: res = m_hi;
         4'b1111: res = m_lo;
         4'b0100: begin
            sa = $signed(a); sb_ = $signed(b); sp = sa * sb_;
            m_hi = sp[63:32]; m_lo = sp[31:0]; res = m_lo; multi = 1;
         end
         4'b0101: begin
            ua = a; ub = b; up = ua * ub;
            m_hi = up[63:32]; m_lo = up[31:0]; res = m_lo; multi = 1;
         end
         4'b1101: begin
            multi = 1;
            if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin
               sa = $signed(a); sb_ = $signed(b);
               q = sa / sb_; r = sa % sb_;
               m_lo = q[31:0]; m_hi = r[31:0];
            end
            res = m_lo;
         end
         default: begin // DIVU
            multi = 1;
            if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin
               ua = a; ub = b;
               m_lo = W'(ua / ub); m_hi = W'(ua % ub);
            end
            res = m_lo;
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Present one op when in_ready is seen; record expected value and completion cycle.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, input logic [SW-1:0] sh);
      logic [W-1:0] res;
      bit           multi;
      exp_t         e;
      int unsigned  guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
      alu_control = op; data1 = a; data2 = b; shamt = sh; in_valid = 1'b1;
      model(op, a, b, sh, res, multi);
      e.val = res; e.op = op;
      e.cyc = cyc + (multi ? W + 1 : 1);
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count busy cycles; optionally hold in_valid with junk to show it is ignored.
   task automatic busy_hold(input bit junk);
      int unsigned n = 0;
      while (busy && n < 100) begin
         chk("in_ready_eq_not_busy", {31'd0, in_ready}, 32'd0);
         if (junk) begin
            in_valid = 1'b1; alu_control = 4'($urandom_range(0, 15));
            data1 = $urandom; data2 = $urandom; shamt = SW'($urandom);
         end
         n++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("busy_cycles", n, W);
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'h7fff_ffff;
         4: return W'($urandom_range(0, 20));
         5: return -W'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every out_valid must match the oldest expected entry, on time.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out_valid out=%h (cycle %0d)", out, cyc);
            end else begin
               e = sb.pop_front();
               if (out !== e.val || zero !== (e.val == '0) || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL result op=%b got=%h zero=%b cyc=%0d exp=%h zero=%b cyc=%0d",
                           e.op, out, zero, cyc, e.val, (e.val == '0), e.cyc);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned guard;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", out, '0);
      chk("reset_zero", {31'd0, zero}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
      issue(4'b0011, '0, '0, '0);                     // MFHI after reset
      issue(4'b1111, '0, '0, '0);                     // MFLO after reset

      // Directed corner cases
      issue(4'b0010, 32'hffff_ffff, 32'h1, '0);       // ADD wraps to zero
      issue(4'b1011, '0, 32'h8000_0000, 5'd4);        // SRA
      issue(4'b1010, '0, 32'h8000_0000, 5'd4);        // SRL
      issue(4'b0100, 32'hffff_fffe, 32'h3, '0);       // MULT -2*3
      busy_hold(1'b1);
      issue(4'b0011, '0, '0, '0);                     // MFHI back-to-back
      issue(4'b1111, '0, '0, '0);
      issue(4'b1101, 32'hffff_fff9, 32'h2, '0);       // DIV -7/2
      issue(4'b0011, '0, '0, '0);
      issue(4'b1110, 32'h5, 32'h0, '0);               // DIVU by zero
      issue(4'b0011, '0, '0, '0);
      issue(4'b1101, 32'h8000_0000, 32'hffff_ffff, '0); // DIV MIN/-1
      issue(4'b0011, '0, '0, '0);
      issue(4'b1101, 32'h8000_0000, 32'h0, '0);       // DIV by zero, negative dividend
      issue(4'b0011, '0, '0, '0);

      // Randomized mix, back-to-back where in_ready allows
      for (int i = 0; i < 80; i++) begin
         issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), SW'($urandom));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      // Reset during a divide aborts it
      guard = 0;
      while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
      repeat (3) begin @(posedge clk); #1; end
      chk("queue_drained_before_abort", sb.size(), 0);
      issue(4'b1110, 32'd100, 32'd7, '0);             // accepted at T, now in T+1
      repeat (9) begin @(posedge clk); #1; end        // now in T+10
      rst_n = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      m_hi = '0; m_lo = '0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (40) begin @(posedge clk); #1; end       // monitor flags any stray out_valid
      issue(4'b1111, '0, '0, '0);                     // MFLO reads 0
      issue(4'b0011, '0, '0, '0);                     // MFHI reads 0

      guard = 0;
      while (sb.size() != 0 && guard < 100) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
